// File: rtl/ifetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_ctrl_pkg
// Description : Shared widths, reset PC, FSM encodings and the redirect
//               priority helper for the instruction fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_ctrl_pkg;

    localparam int          XLEN_DEFAULT     = 64;
    localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;

    // Fetch FSM encodings
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FETCH = 1'b1;

    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_FLUSH  = 2'd1,
        REDIR_TRAP   = 2'd2,
        REDIR_BRANCH = 2'd3
    } redir_e;

    // Flush beats trap, trap beats branch.
    function automatic redir_e redir_sel(input logic flush, input logic trap, input logic branch);
        redir_e sel;
        sel = REDIR_NONE;
        if (flush)       sel = REDIR_FLUSH;
        else if (trap)   sel = REDIR_TRAP;
        else if (branch) sel = REDIR_BRANCH;
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_ctrl_if
// Description : Instruction bus request/response and IF/ID hand-off signals.
//               master = fetch controller, slave = bus plus decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_ctrl_if
    import ifetch_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    logic            req_valid_o;
    logic [XLEN-1:0] req_addr_o;
    logic            addr_ok_i;
    logic            rdata_valid_i;
    logic [31:0]     rdata_i;
    logic            inst_valid_o;
    logic [31:0]     inst_o;
    logic [XLEN-1:0] inst_pc_o;
    logic            inst_ready_i;

    modport master (
        output req_valid_o, req_addr_o,
        input  addr_ok_i, rdata_valid_i, rdata_i,
        output inst_valid_o, inst_o, inst_pc_o,
        input  inst_ready_i
    );

    modport slave (
        input  req_valid_o, req_addr_o,
        output addr_ok_i, rdata_valid_i, rdata_i,
        input  inst_valid_o, inst_o, inst_pc_o,
        output inst_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_ctrl_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_ctrl_sync_fifo
// Description : Small synchronous FIFO with clear, used for pending fetch PCs
//               and for buffered fetch responses.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_ctrl_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         push,
    input  wire logic [WIDTH-1:0]             push_data,
    input  wire logic                         pop,
    input  wire logic                         clear,
    output logic      [WIDTH-1:0]             pop_data,
    output logic                              full,
    output logic                              empty,
    output logic      [$clog2(DEPTH+1)-1:0]   count
);
    localparam int            CW     = $clog2(DEPTH + 1);
    localparam int            AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; clear wins over any same-cycle push/pop
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push && !clear) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_ctrl
// Description : Owns the fetch PC, issues in-order bus reads with a credit
//               limit of DEPTH, discards responses made stale by redirects
//               and buffers fetched words for the IF/ID stage.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter int              XLEN          = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] PC_RESET_ADDR = XLEN'(PC_RESET_DEFAULT),
    parameter int              DEPTH         = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            stall_i,
    input  wire logic            flush_i,
    input  wire logic            clint_pc_valid_i,
    input  wire logic [XLEN-1:0] clint_pc_i,
    input  wire logic            branch_pc_valid_i,
    input  wire logic [XLEN-1:0] branch_pc_i,
    ifetch_ctrl_if.master        bus,
    output logic                 protocol_err_o
);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] c_depth = (CW + 1)'(DEPTH);

    logic [0:0]         r_state;
    logic [XLEN-1:0]    r_pc;
    logic [CW-1:0]      r_kill_cnt;
    logic               r_protocol_err;

    logic [CW-1:0]      w_pend_cnt;
    logic [CW-1:0]      w_buf_cnt;
    logic [CW:0]        w_credit_used;
    logic [CW-1:0]      w_pend_next;
    logic               w_pend_full, w_pend_empty;
    logic               w_buf_full, w_buf_empty;
    logic [XLEN-1:0]    w_pend_head;
    logic [XLEN+31:0]   w_buf_head;
    logic               w_fetch, w_req_valid, w_accept;
    redir_e             w_redir;
    logic               w_redirect, w_kill_redirect;
    logic [XLEN-1:0]    w_target;
    logic               w_rsp_legal, w_rsp_kill;
    logic               w_buf_push, w_buf_pop;

    assign w_fetch       = (r_state == S_FETCH);
    assign w_credit_used = {1'b0, w_pend_cnt} + {1'b0, w_buf_cnt};
    // The full flags are implied by the credit sum; kept as a guard on the FIFOs
    assign w_req_valid   = w_fetch & ~stall_i & (w_credit_used < c_depth) & ~w_pend_full & ~w_buf_full;
    assign w_accept      = w_req_valid & bus.addr_ok_i;

    assign w_redir         = redir_sel(flush_i, clint_pc_valid_i, branch_pc_valid_i);
    assign w_redirect      = (w_redir != REDIR_NONE);
    assign w_kill_redirect = w_fetch & w_redirect;

    // Redirect target selection
    always_comb begin
        w_target = branch_pc_i;
        case (w_redir)
            REDIR_FLUSH: w_target = PC_RESET_ADDR;
            REDIR_TRAP:  w_target = clint_pc_i;
            default:     w_target = branch_pc_i;
        endcase
    end

    // Responses with nothing pending are dropped; stale ones are popped but discarded
    assign w_rsp_legal = bus.rdata_valid_i & ~w_pend_empty;
    assign w_rsp_kill  = w_rsp_legal & (r_kill_cnt != '0);
    assign w_buf_push  = w_rsp_legal & ~w_rsp_kill & ~w_kill_redirect;
    assign w_buf_pop   = ~w_buf_empty & bus.inst_ready_i & ~w_kill_redirect;
    assign w_pend_next = w_pend_cnt + CW'(w_accept) - CW'(w_rsp_legal);

    ifetch_ctrl_sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pend_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_accept),
        .push_data (r_pc),
        .pop       (w_rsp_legal),
        .clear     (1'b0),
        .pop_data  (w_pend_head),
        .full      (w_pend_full),
        .empty     (w_pend_empty),
        .count     (w_pend_cnt)
    );

    ifetch_ctrl_sync_fifo #(.WIDTH(XLEN + 32), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_buf_push),
        .push_data ({w_pend_head, bus.rdata_i}),
        .pop       (w_buf_pop),
        .clear     (w_kill_redirect),
        .pop_data  (w_buf_head),
        .full      (w_buf_full),
        .empty     (w_buf_empty),
        .count     (w_buf_cnt)
    );

    // Idle for exactly one cycle after reset, then fetch forever
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= S_FETCH;
    end

    // Fetch PC: a redirect overrides the sequential advance
    always_ff @(posedge clk) begin
        if (rst)             r_pc <= PC_RESET_ADDR;
        else if (w_redirect) r_pc <= w_target;
        else if (w_accept)   r_pc <= r_pc + XLEN'(4);
    end

    // Number of in-flight requests whose responses must be thrown away
    always_ff @(posedge clk) begin
        if (rst)                  r_kill_cnt <= '0;
        else if (w_kill_redirect) r_kill_cnt <= w_pend_next;
        else if (w_rsp_kill)      r_kill_cnt <= r_kill_cnt - 1'b1;
    end

    // Sticky flag for a response that had no matching request
    always_ff @(posedge clk) begin
        if (rst)                                      r_protocol_err <= 1'b0;
        else if (bus.rdata_valid_i && w_pend_empty)   r_protocol_err <= 1'b1;
    end

    assign bus.req_valid_o  = w_req_valid;
    assign bus.req_addr_o   = r_pc;
    assign bus.inst_valid_o = ~w_buf_empty;
    assign bus.inst_pc_o    = w_buf_head[XLEN+31:32];
    assign bus.inst_o       = w_buf_head[31:0];
    assign protocol_err_o   = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_ctrl
// Description : Directed bench for ifetch_ctrl with a bus responder model,
//               a reference fetch-PC model and an IF/ID scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_ctrl;

    localparam logic [63:0] c_reset_pc = 64'h8000_0000;

    typedef struct {logic [63:0] addr; logic kill;} bus_t;
    typedef struct {logic [63:0] pc; logic [31:0] word;} sb_t;

    logic        clk;
    logic        rst;
    logic        stall, flush, clint_v, br_v;
    logic [63:0] clint_pc, br_pc;
    logic        protocol_err;
    logic        bus_hold, inject;

    int n_chk = 0, n_pass = 0, n_fail = 0, n_deliv = 0;
    bus_t bus_q[$];
    sb_t  exp_q[$];
    logic [63:0] m_pc;

    ifetch_ctrl_if #(.XLEN(64)) bus_if ();

    ifetch_ctrl #(.XLEN(64), .PC_RESET_ADDR(c_reset_pc), .DEPTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_i           (stall),
        .flush_i           (flush),
        .clint_pc_valid_i  (clint_v),
        .clint_pc_i        (clint_pc),
        .branch_pc_valid_i (br_v),
        .branch_pc_i       (br_pc),
        .bus               (bus_if),
        .protocol_err_o    (protocol_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk_w(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Inputs change on the falling edge; redirect pulses last one cycle
    task automatic step();
        @(negedge clk);
        flush   = 1'b0;
        clint_v = 1'b0;
        br_v    = 1'b0;
    endtask

    // Bus responder: answers each accepted request one cycle later, in order
    initial begin : bus_model
        bus_t e;
        logic redir;
        logic [63:0] target;
        bus_if.rdata_valid_i = 1'b0;
        bus_if.rdata_i       = '0;
        m_pc = c_reset_pc;
        forever begin
            @(negedge clk);
            #1;
            redir = flush | clint_v | br_v;
            bus_if.rdata_valid_i = 1'b0;
            bus_if.rdata_i       = '0;
            if (inject) begin
                bus_if.rdata_valid_i = 1'b1;
                bus_if.rdata_i       = 32'hDEAD_BEEF;
            end else if (!bus_hold && bus_q.size() > 0) begin
                e = bus_q.pop_front();
                bus_if.rdata_valid_i = 1'b1;
                bus_if.rdata_i       = word_of(e.addr);
                if (!e.kill && !redir) exp_q.push_back('{e.addr, word_of(e.addr)});
            end
            if (redir) foreach (bus_q[i]) bus_q[i].kill = 1'b1;
            #3;
            if (rst) begin
                bus_q.delete();
                exp_q.delete();
                m_pc = c_reset_pc;
            end else begin
                target = flush ? c_reset_pc : (clint_v ? clint_pc : br_pc);
                if (bus_if.req_valid_o && bus_if.addr_ok_i) begin
                    chk_w("req_addr_order", bus_if.req_addr_o, m_pc);
                    bus_q.push_back('{m_pc, redir});
                end
                if (redir) m_pc = target;
                else if (bus_if.req_valid_o && bus_if.addr_ok_i) m_pc = m_pc + 64'd4;
            end
        end
    end

    // IF/ID scoreboard: every consumed instruction must match the next expected one
    initial begin : sb_monitor
        sb_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && bus_if.inst_valid_o && bus_if.inst_ready_i) begin
                chk_b("inst_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk_w("inst_pc", bus_if.inst_pc_o, e.pc);
                    chk_w("inst_word", {32'h0, bus_if.inst_o}, {32'h0, e.word});
                    n_deliv++;
                end
            end
        end
    end

    initial begin : directed
        rst = 1'b1; stall = 1'b0; flush = 1'b0; clint_v = 1'b0; br_v = 1'b0;
        clint_pc = '0; br_pc = '0; bus_hold = 1'b0; inject = 1'b0;
        bus_if.addr_ok_i = 1'b0; bus_if.inst_ready_i = 1'b0;

        // Reset state and the single idle cycle
        repeat (3) step();
        #2;
        chk_b("rst_req_valid", bus_if.req_valid_o, 1'b0);
        chk_b("rst_inst_valid", bus_if.inst_valid_o, 1'b0);
        chk_b("rst_protocol_err", protocol_err, 1'b0);
        chk_w("rst_pc", bus_if.req_addr_o, c_reset_pc);
        step(); rst = 1'b0; #2;
        chk_b("idle_no_req", bus_if.req_valid_o, 1'b0);
        step(); #2;
        chk_b("fetch_req_valid", bus_if.req_valid_o, 1'b1);

        // Streaming fetch, always accepted, always consumed
        bus_if.addr_ok_i = 1'b1; bus_if.inst_ready_i = 1'b1;
        repeat (12) step();
        bus_if.addr_ok_i = 1'b0;
        repeat (4) step();
        #2;
        chk_w("t1_drained", 64'(exp_q.size()), 64'd0);
        chk_b("t1_delivered", n_deliv >= 5, 1'b1);

        // Credit exhaustion with downstream stalled
        step(); bus_if.addr_ok_i = 1'b1; bus_if.inst_ready_i = 1'b0; #2;
        chk_b("t2_req_a", bus_if.req_valid_o, 1'b1);
        step(); #2; chk_b("t2_req_b", bus_if.req_valid_o, 1'b1);
        step(); #2; chk_b("t2_credit_block", bus_if.req_valid_o, 1'b0);
        step(); #2;
        chk_b("t2_full_block", bus_if.req_valid_o, 1'b0);
        chk_b("t2_buf_valid", bus_if.inst_valid_o, 1'b1);
        step(); bus_if.inst_ready_i = 1'b1; #2;
        chk_b("t2_pop_cycle", bus_if.req_valid_o, 1'b0);
        step(); bus_if.inst_ready_i = 1'b0; bus_if.addr_ok_i = 1'b0; #2;
        chk_b("t2_reissue", bus_if.req_valid_o, 1'b1);
        step(); bus_if.inst_ready_i = 1'b1;
        repeat (3) step();

        // Branch with two requests outstanding
        step(); flush = 1'b1;
        step(); bus_if.addr_ok_i = 1'b1; bus_hold = 1'b1; bus_if.inst_ready_i = 1'b0; #2;
        chk_w("t3_flush_pc", bus_if.req_addr_o, 64'h8000_0000);
        step(); #2; chk_b("t3_second_req", bus_if.req_valid_o, 1'b1);
        step(); br_v = 1'b1; br_pc = 64'h8000_1000; #2;
        chk_b("t3_credit_full", bus_if.req_valid_o, 1'b0);
        step(); bus_hold = 1'b0; #2;
        chk_w("t3_branch_pc", bus_if.req_addr_o, 64'h8000_1000);
        chk_b("t3_killed_hold_credit", bus_if.req_valid_o, 1'b0);
        step(); #2;
        chk_b("t3_resume", bus_if.req_valid_o, 1'b1);
        chk_b("t3_kill0_dropped", bus_if.inst_valid_o, 1'b0);
        step(); bus_if.addr_ok_i = 1'b0; #2;
        chk_b("t3_kill1_dropped", bus_if.inst_valid_o, 1'b0);
        step(); bus_if.inst_ready_i = 1'b1; #2;
        chk_b("t3_first_valid", bus_if.inst_valid_o, 1'b1);
        chk_w("t3_first_pc", bus_if.inst_pc_o, 64'h8000_1000);
        repeat (3) step();

        // Simultaneous flush, trap and branch together with an accept
        step(); bus_if.inst_ready_i = 1'b0; bus_if.addr_ok_i = 1'b1;
        flush = 1'b1; clint_v = 1'b1; clint_pc = 64'h8000_0100;
        br_v = 1'b1; br_pc = 64'h8000_2000; #2;
        chk_b("t4_accept_with_redirect", bus_if.req_valid_o, 1'b1);
        step(); bus_if.addr_ok_i = 1'b0; #2;
        chk_w("t4_flush_wins", bus_if.req_addr_o, 64'h8000_0000);
        step(); bus_if.addr_ok_i = 1'b1; #2;
        chk_b("t4_killed_dropped", bus_if.inst_valid_o, 1'b0);
        step(); bus_if.addr_ok_i = 1'b0;
        step(); bus_if.inst_ready_i = 1'b1; #2;
        chk_b("t4_new_valid", bus_if.inst_valid_o, 1'b1);
        chk_w("t4_new_pc", bus_if.inst_pc_o, 64'h8000_0000);
        repeat (2) step();

        // Five-cycle stall with one request in flight
        step(); bus_if.addr_ok_i = 1'b1; bus_hold = 1'b1; #2;
        chk_w("t5_issue", bus_if.req_addr_o, 64'h8000_0004);
        step(); stall = 1'b1; #2; chk_b("t5_stall_c1", bus_if.req_valid_o, 1'b0);
        step(); bus_hold = 1'b0; #2; chk_b("t5_stall_c2", bus_if.req_valid_o, 1'b0);
        step(); #2;
        chk_b("t5_stall_c3", bus_if.req_valid_o, 1'b0);
        chk_b("t5_rsp_valid", bus_if.inst_valid_o, 1'b1);
        chk_w("t5_rsp_pc", bus_if.inst_pc_o, 64'h8000_0004);
        step(); #2; chk_b("t5_stall_c4", bus_if.req_valid_o, 1'b0);
        step(); #2; chk_b("t5_stall_c5", bus_if.req_valid_o, 1'b0);
        step(); stall = 1'b0; #2;
        chk_b("t5_resume", bus_if.req_valid_o, 1'b1);
        chk_w("t5_resume_pc", bus_if.req_addr_o, 64'h8000_0008);
        step(); bus_if.addr_ok_i = 1'b0;
        repeat (3) step();

        // Response with nothing pending
        step(); inject = 1'b1; #2;
        chk_b("t6_no_err_yet", protocol_err, 1'b0);
        step(); inject = 1'b0; #2;
        chk_b("t6_err_set", protocol_err, 1'b1);
        chk_b("t6_no_inst", bus_if.inst_valid_o, 1'b0);
        repeat (3) step();
        #2;
        chk_b("t6_err_sticky", protocol_err, 1'b1);
        chk_w("sb_drained", 64'(exp_q.size()), 64'd0);
        step(); rst = 1'b1;
        step(); #2;
        chk_b("t6_err_cleared", protocol_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
